// File: rtl/sci_slave_if.sv
// Bus bundle between an SCI responder and its neuron register file.
// The slave modport is the responder side. The master modport drives the serial
// request and the register read data.
interface sci_slave_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  sci_csn;
  logic                  sci_req;
  logic                  sci_resp;
  logic                  sci_ack;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic                  reg_wen;
  logic [DATA_WIDTH-1:0] reg_rdata;

  modport slave (
    input  sci_csn, sci_req, reg_rdata,
    output sci_resp, sci_ack, reg_addr, reg_wdata, reg_wen
  );

  modport master (
    output sci_csn, sci_req, reg_rdata,
    input  sci_resp, sci_ack, reg_addr, reg_wdata, reg_wen
  );
endinterface

// File: rtl/sci_slave.sv
// SCI responder: decodes serial write/read frames into single-cycle register-file
// accesses and returns read data serially, MSB first. Assumes 2 <= ADDR_WIDTH <= DATA_WIDTH.
module sci_slave #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  sci_slave_if.slave  bus
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    LOAD,
    RDATA,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic                  ack_q, ack_d;
  logic                  resp_q, resp_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      ack_q   <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      ack_q   <= ack_d;
      resp_q  <= resp_d;
    end
  end

  // Strobes and RESP default low every cycle, so an abort can never leave them set.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    ack_d   = 1'b0;
    resp_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.sci_csn) begin
          cmd_d   = bus.sci_req;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (bus.sci_csn) begin
          state_d = IDLE;
        end else begin
          shift_d = {shift_q[DATA_WIDTH-2:0], bus.sci_req};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            addr_d  = {shift_q[ADDR_WIDTH-2:0], bus.sci_req};
            cnt_d   = '0;
            state_d = cmd_q ? WDATA : LOAD;
          end
        end
      end

      WDATA: begin
        if (bus.sci_csn) begin
          state_d = IDLE;
        end else begin
          shift_d = {shift_q[DATA_WIDTH-2:0], bus.sci_req};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            wdata_d = {shift_q[DATA_WIDTH-2:0], bus.sci_req};
            wen_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        state_d = bus.sci_csn ? IDLE : DONE;
      end

      // The MSB goes straight to RESP; the rest is pre-shifted so RDATA always sends the top bit.
      LOAD: begin
        if (bus.sci_csn) begin
          state_d = IDLE;
        end else begin
          resp_d  = bus.reg_rdata[DATA_WIDTH-1];
          shift_d = {bus.reg_rdata[DATA_WIDTH-2:0], 1'b0};
          cnt_d   = CNT_W'(DATA_WIDTH - 1);
          state_d = RDATA;
        end
      end

      RDATA: begin
        if (bus.sci_csn) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          resp_d  = shift_q[DATA_WIDTH-1];
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q - 1'b1;
        end
      end

      DONE: begin
        if (bus.sci_csn) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wen   = wen_q;
  assign bus.sci_ack   = ack_q;
  assign bus.sci_resp  = resp_q;

endmodule

// File: tb/tb_sci_slave.sv
// Self-checking bench for sci_slave: a vector table plus hand-written corner sequences.
// A negedge monitor pops expected frames from a scoreboard queue whenever ACK is seen.
module tb_sci_slave;

  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sci_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sci_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file model sitting behind the responder.
  logic [DW-1:0] tb_regs [32] = '{default: 8'h00};

  always_comb bus.reg_rdata = tb_regs[bus.reg_addr];

  always @(posedge clk) begin
    if (bus.reg_wen) tb_regs[bus.reg_addr] <= bus.reg_wdata;
  end

  typedef struct {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  ack_count = 0;
  int  wen_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic csn, input logic req);
    bus.sci_csn = csn;
    bus.sci_req = req;
    @(posedge clk);
    #1;
  endtask

  // One complete frame followed by a single CSN-high cycle.
  task automatic applyStimulus(input logic cmd, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data);
    sb_t e;
    e.cmd  = cmd;
    e.addr = addr;
    e.data = exp_data;
    sb.push_back(e);
    drive(1'b0, cmd);
    for (int i = AW - 1; i >= 0; i--) drive(1'b0, addr[i]);
    if (cmd) begin
      for (int i = DW - 1; i >= 0; i--) drive(1'b0, wdata[i]);
    end else begin
      repeat (DW + 1) drive(1'b0, 1'b0);
    end
    drive(1'b1, 1'b0);
  endtask

  // Monitor: the DW RESP samples preceding an ACK form the read word.
  logic [DW-1:0] resp_hist = '0;
  logic          prev_wen  = 1'b0;

  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      if (bus.reg_wen) begin
        wen_count++;
        checkOutput("ack_with_wen", 32'(bus.sci_ack), 32'd1);
        checkOutput("wen_single_cycle", 32'(prev_wen), 32'd0);
      end
      if (bus.sci_ack) begin
        ack_count++;
        checkOutput("ack_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("ack_addr", 32'(bus.reg_addr), 32'(e.addr));
          checkOutput("ack_wen", 32'(bus.reg_wen), 32'(e.cmd));
          if (e.cmd) begin
            checkOutput("wdata", 32'(bus.reg_wdata), 32'(e.data));
          end else begin
            checkOutput("rdata_serial", 32'(resp_hist), 32'(e.data));
            checkOutput("resp_at_ack", 32'(bus.sci_resp), 32'd0);
          end
        end
      end
    end
    resp_hist = {resp_hist[DW-2:0], bus.sci_resp};
    prev_wen  = bus.reg_wen;
  end

  vec_t vecs [10];
  int   a0, w0;

  initial begin
    vecs[0] = '{1'b1, 5'h03, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 5'h10, 8'h3C, 8'h3C};
    vecs[2] = '{1'b0, 5'h10, 8'h00, 8'h3C};
    vecs[3] = '{1'b0, 5'h03, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 5'h00, 8'hFF, 8'hFF};
    vecs[5] = '{1'b1, 5'h1F, 8'h81, 8'h81};
    vecs[6] = '{1'b0, 5'h00, 8'h00, 8'hFF};
    vecs[7] = '{1'b0, 5'h1F, 8'h00, 8'h81};
    vecs[8] = '{1'b1, 5'h0A, 8'h00, 8'h00};
    vecs[9] = '{1'b0, 5'h0A, 8'h00, 8'h00};

    rst = 1'b1;
    bus.sci_csn = 1'b1;
    bus.sci_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_resp", 32'(bus.sci_resp), 32'd0);
    checkOutput("rst_ack", 32'(bus.sci_ack), 32'd0);
    checkOutput("rst_wen", 32'(bus.reg_wen), 32'd0);
    checkOutput("rst_addr", 32'(bus.reg_addr), 32'd0);
    checkOutput("rst_wdata", 32'(bus.reg_wdata), 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0);

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data);
    end

    $display("[TB] abort after 3 address bits");
    a0 = ack_count;
    w0 = wen_count;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    checkOutput("abort_no_ack", 32'(ack_count - a0), 32'd0);
    checkOutput("abort_no_wen", 32'(wen_count - w0), 32'd0);
    applyStimulus(1'b1, 5'h07, 8'h5A, 8'h5A);
    applyStimulus(1'b0, 5'h07, 8'h00, 8'h5A);

    $display("[TB] reset during RDATA");
    drive(1'b0, 1'b0);
    for (int i = AW - 1; i >= 0; i--) drive(1'b0, (i == 4) ? 1'b1 : 1'b0);
    repeat (4) drive(1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_resp", 32'(bus.sci_resp), 32'd0);
    checkOutput("midrst_ack", 32'(bus.sci_ack), 32'd0);
    checkOutput("midrst_wen", 32'(bus.reg_wen), 32'd0);
    checkOutput("midrst_addr", 32'(bus.reg_addr), 32'd0);
    checkOutput("midrst_wdata", 32'(bus.reg_wdata), 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0);
    applyStimulus(1'b0, 5'h03, 8'h00, 8'hA5);

    $display("[TB] CSN held low after ACK");
    a0 = ack_count;
    w0 = wen_count;
    sb.push_back('{1'b1, 5'h09, 8'hC3});
    drive(1'b0, 1'b1);
    for (int i = AW - 1; i >= 0; i--) drive(1'b0, ((5'h09 >> i) & 5'h01) != 5'h00);
    for (int i = DW - 1; i >= 0; i--) drive(1'b0, ((8'hC3 >> i) & 8'h01) != 8'h00);
    for (int i = 0; i < 5; i++) drive(1'b0, i[0]);
    checkOutput("held_one_ack", 32'(ack_count - a0), 32'd1);
    checkOutput("held_one_wen", 32'(wen_count - w0), 32'd1);
    drive(1'b1, 1'b0);
    applyStimulus(1'b0, 5'h09, 8'h00, 8'hC3);

    $display("[TB] back-to-back writes and readback 0..16");
    for (int a = 0; a < 17; a++) begin
      applyStimulus(1'b1, AW'(a), DW'(a * 29 + 11), DW'(a * 29 + 11));
    end
    for (int a = 0; a < 17; a++) begin
      applyStimulus(1'b0, AW'(a), 8'h00, DW'(a * 29 + 11));
    end

    repeat (3) drive(1'b1, 1'b0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
